epass_checker: RTL and testbench

EPASS_CHECKER -- requirements
Module: epass_checker

---
 rtl/epass_checker.sv | 129 ++++++++++++
 tb/tb_epass_checker.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/epass_checker.sv
// Electronic toll pass checker: reads a tag, debits the fee from a 16-entry balance table, and reports paid or rejected.
// Optional per-account blacklist is enabled with `define EPASS_BLACKLIST_EN.
module epass_checker #(
  parameter int         TIMEOUT_CYC  = 200,
  parameter logic [7:0] INIT_BALANCE = 8'd0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       read_req,
  input  logic [7:0] fee,
  input  logic       tag_present,
  input  logic [3:0] tag_id,
  input  logic       clear,
  input  logic       topup_we,
  input  logic [3:0] topup_id,
  input  logic [7:0] topup_amt,
`ifdef EPASS_BLACKLIST_EN
  input  logic       bl_we,
  input  logic [3:0] bl_id,
  input  logic       bl_val,
`endif
  output logic [1:0] valid_Epass,
  output logic       busy,
  output logic [7:0] balance_out
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] READ   = 2'd1;
  localparam logic [1:0] CHECK  = 2'd2;
  localparam logic [1:0] RESULT = 2'd3;

  logic [1:0]    state;
  logic [7:0]    fee_q;
  logic [3:0]    id_q;
  logic [CW-1:0] cnt;
  logic [7:0]    bal [16];
  logic [8:0]    sum [16];
  logic [7:0]    nxt [16];
  logic          pay_ok;
  logic          ded;

`ifdef EPASS_BLACKLIST_EN
  logic [15:0] bl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bl <= '0;
    end else if (bl_we) begin
      bl[bl_id] <= bl_val;
    end
  end

  assign pay_ok = (bal[id_q] >= fee_q) && !bl[id_q];
`else
  assign pay_ok = (bal[id_q] >= fee_q);
`endif

  assign ded  = (state == CHECK) && pay_ok;
  assign busy = (state != IDLE);

  // Debit cannot underflow (only applied when sufficient); the 9th bit catches top-up overflow.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sum[i] = {1'b0, bal[i]};
      if (ded && (id_q == 4'(i)))
        sum[i] = sum[i] - {1'b0, fee_q};
      if (topup_we && (topup_id == 4'(i)))
        sum[i] = sum[i] + {1'b0, topup_amt};
      nxt[i] = sum[i][8] ? 8'hFF : sum[i][7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) bal[i] <= INIT_BALANCE;
    end else begin
      for (int i = 0; i < 16; i++) bal[i] <= nxt[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fee_q       <= 8'd0;
      id_q        <= 4'd0;
      cnt         <= '0;
      valid_Epass <= 2'b00;
      balance_out <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (read_req) begin
            fee_q <= fee;
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (tag_present) begin
            id_q  <= tag_id;
            state <= CHECK;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT_CYC - 1)) begin
              state       <= RESULT;
              valid_Epass <= 2'b01;
            end
          end
        end
        CHECK: begin
          state       <= RESULT;
          valid_Epass <= pay_ok ? 2'b10 : 2'b01;
          // Reports the value actually stored, including a same-cycle top-up.
          balance_out <= nxt[id_q];
        end
        RESULT: begin
          if (clear) begin
            state       <= IDLE;
            valid_Epass <= 2'b00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_epass_checker.sv
// Scoreboarded random/directed bench for epass_checker against a table-level balance model.
module tb_epass_checker;

  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       read_req;
  logic [7:0] fee;
  logic       tag_present;
  logic [3:0] tag_id;
  logic       clear;
  logic       topup_we;
  logic [3:0] topup_id;
  logic [7:0] topup_amt;
  logic [1:0] valid_Epass;
  logic       busy;
  logic [7:0] balance_out;
`ifdef EPASS_BLACKLIST_EN
  logic       bl_we;
  logic [3:0] bl_id;
  logic       bl_val;
`endif

  int total = 0;
  int bad   = 0;

  int mbal [16];
  bit mbl  [16];
  int exp_bo;
  logic [9:0] sb [$];
  logic [1:0] prev_v = 2'b00;

  always #5 clk = ~clk;

  epass_checker #(.TIMEOUT_CYC(T), .INIT_BALANCE(8'd0)) dut (
    .clk(clk), .reset_n(reset_n), .read_req(read_req), .fee(fee),
    .tag_present(tag_present), .tag_id(tag_id), .clear(clear),
    .topup_we(topup_we), .topup_id(topup_id), .topup_amt(topup_amt),
`ifdef EPASS_BLACKLIST_EN
    .bl_we(bl_we), .bl_id(bl_id), .bl_val(bl_val),
`endif
    .valid_Epass(valid_Epass), .busy(busy), .balance_out(balance_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every rising of valid_Epass away from 00 is one reported result.
  always @(negedge clk) begin
    if (valid_Epass == 2'b11) begin
      total++; bad++;
      $display("FAIL illegal_valid actual=3 required=not3");
    end
    if (valid_Epass != 2'b00 && prev_v == 2'b00) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result actual=%0d/%0d required=none", valid_Epass, balance_out);
      end else begin
        logic [9:0] e;
        e = sb.pop_front();
        if ({valid_Epass, balance_out} !== e) begin
          bad++;
          $display("FAIL result actual=%0d/%0d required=%0d/%0d",
                   valid_Epass, balance_out, e[9:8], e[7:0]);
        end
      end
    end
    prev_v = valid_Epass;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic do_topup(input int id, input int amt);
    topup_we = 1'b1; topup_id = 4'(id); topup_amt = 8'(amt);
    tick();
    topup_we = 1'b0;
    mbal[id] = sat(mbal[id] + amt);
  endtask

  task automatic hold_and_clear(input int v);
    int n;
    n = $urandom_range(1, 4);
    repeat (n) begin
      read_req = 1'($urandom_range(0, 1));
      fee = 8'($urandom);
      tick();
      chk("hold_valid", valid_Epass, v);
      chk("hold_busy", busy, 1);
    end
    read_req = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_valid", valid_Epass, 0);
    chk("clear_busy", busy, 0);
    chk("balance_out", balance_out, exp_bo);
  endtask

  task automatic txn(input int id, input int f, input int dly,
                     input bit tu, input int tid, input int tamt);
    int b, nb;
    bit ok;
    read_req = 1'b1; fee = 8'(f);
    tick();
    read_req = 1'b0; fee = 8'($urandom);
    chk("busy_read", busy, 1);
    repeat (dly) tick();
    tag_present = 1'b1; tag_id = 4'(id);
    tick();
    tag_present = 1'b0; tag_id = 4'($urandom);
    b  = mbal[id];
    ok = (b >= f) && !mbl[id];
    nb = ok ? b - f : b;
    if (tu) begin
      topup_we = 1'b1; topup_id = 4'(tid); topup_amt = 8'(tamt);
      if (tid == id) nb = sat(nb + tamt);
      else mbal[tid] = sat(mbal[tid] + tamt);
    end
    mbal[id] = nb;
    exp_bo = nb;
    sb.push_back({ok ? 2'b10 : 2'b01, 8'(nb)});
    tick();
    topup_we = 1'b0;
    hold_and_clear(ok ? 2 : 1);
  endtask

  initial begin
    reset_n = 1'b0; read_req = 0; fee = 0; tag_present = 0; tag_id = 0;
    clear = 0; topup_we = 0; topup_id = 0; topup_amt = 0;
`ifdef EPASS_BLACKLIST_EN
    bl_we = 0; bl_id = 0; bl_val = 0;
`endif
    for (int i = 0; i < 16; i++) begin mbal[i] = 0; mbl[i] = 0; end
    exp_bo = 0;
    #2;
    chk("rst_valid", valid_Epass, 0);
    chk("rst_busy", busy, 0);
    chk("rst_balance_out", balance_out, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Basic paid transaction
    do_topup(3, 100);
    txn(3, 30, 2, 0, 0, 0);
    // Insufficient funds
    do_topup(5, 20);
    txn(5, 30, 0, 0, 0, 0);

    // Timeout with no tag
    read_req = 1'b1; fee = 8'd9;
    tick();
    read_req = 1'b0;
    repeat (T - 1) begin
      tick();
      chk("to_busy", busy, 1);
      chk("to_valid", valid_Epass, 0);
    end
    sb.push_back({2'b01, 8'(exp_bo)});
    tick();
    hold_and_clear(1);

    // Saturation, fee=0, same-cycle top-up and deduction
    do_topup(1, 250);
    do_topup(1, 50);
    txn(1, 0, 1, 0, 0, 0);
    do_topup(7, 50);
    txn(7, 40, 0, 1, 7, 10);
    txn(7, 20, 3, 1, 7, 250);

    // Reset during CHECK abandons the transaction
    read_req = 1'b1; fee = 8'd5;
    tick();
    read_req = 1'b0;
    tag_present = 1'b1; tag_id = 4'd3;
    tick();
    tag_present = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", valid_Epass, 0);
    chk("arst_busy", busy, 0);
    chk("arst_balance_out", balance_out, 0);
    for (int i = 0; i < 16; i++) mbal[i] = 0;
    exp_bo = 0;
    tick();
    reset_n = 1'b1;
    tick();
    txn(3, 5, 0, 0, 0, 0);

`ifdef EPASS_BLACKLIST_EN
    do_topup(2, 200);
    bl_we = 1; bl_id = 4'd2; bl_val = 1;
    tick();
    bl_we = 0; mbl[2] = 1;
    txn(2, 10, 0, 0, 0, 0);
    bl_we = 1; bl_id = 4'd2; bl_val = 0;
    tick();
    bl_we = 0; mbl[2] = 0;
    txn(2, 10, 0, 0, 0, 0);
`endif

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1)) do_topup($urandom_range(0, 15), $urandom_range(0, 255));
      txn($urandom_range(0, 15), $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 160),
          $urandom_range(0, T - 2), 1'($urandom_range(0, 1)),
          $urandom_range(0, 15), $urandom_range(0, 255));
    end

    tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
